// File: rtl/core_seq_pkg.sv
// Shared types and helpers for the core_seq sequencer and datapath.
package core_seq_pkg;

  typedef enum logic [2:0] {IDLE, KLOAD, KGAP, EXEC, DRAIN, DONE} state_t;

  // mem_sel encodings; 2'd3 is reserved and selects nothing
  localparam logic [1:0] SEL_Q = 2'd0;
  localparam logic [1:0] SEL_K = 2'd1;
  localparam logic [1:0] SEL_P = 2'd2;

  localparam int ROW_MAX = 2048;

  // Sum of |lane| over `lanes` two's-complement lanes of width `lw` packed in row.
  function automatic logic [31:0] abs_sum(input logic [ROW_MAX-1:0] row,
                                          input int lanes, input int lw);
    logic [31:0] acc;
    logic [63:0] lane;
    logic [63:0] mask;
    acc  = '0;
    mask = (64'd1 << lw) - 64'd1;
    for (int i = 0; i < 64; i++) begin
      if (i < lanes) begin
        lane = 64'(row >> (i * lw)) & mask;
        if (((lane >> (lw - 1)) & 64'd1) != 64'd0) lane = mask + 64'd1 - lane;
        acc = acc + 32'(lane);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/core_seq_fsm.sv
// Command sequencer: kernel load, execute, drain; drives SRAM ports, mac inst and ofifo reads.
// state | meaning
// IDLE  | host SRAM access, waits for a command
// KLOAD | reads col kmem rows into the mac array
// KGAP  | one bubble between load and execute
// EXEC  | streams len qmem rows through the mac array
// DRAIN | moves ofifo rows into pmem
// DONE  | one-cycle done pulse
module core_seq_fsm
  import core_seq_pkg::*;
#(
  parameter int col   = 8,
  parameter int depth = 16,
  parameter int aw    = $clog2(depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [aw:0]   cmd_len,
  input  logic [aw-1:0] cmd_k_base,
  input  logic [aw-1:0] cmd_q_base,
  input  logic [aw-1:0] cmd_p_base,
  input  logic          mem_wr,
  input  logic [1:0]    mem_sel,
  input  logic [aw-1:0] mem_add,
  input  logic          row_wr,
  output logic          cmd_ready,
  output logic          done,
  output logic          q_ce,
  output logic          q_we,
  output logic [aw-1:0] q_addr,
  output logic          k_ce,
  output logic          k_we,
  output logic [aw-1:0] k_addr,
  output logic          p_ce,
  output logic          p_we,
  output logic [aw-1:0] p_addr,
  output logic          host_p_rd,
  output logic [1:0]    inst,
  output logic          ofifo_rd
);

  localparam int cw = $clog2(col + depth + 2);

  state_t        state, state_nxt;
  logic [aw:0]   len, avail, written;
  logic [aw-1:0] k_base, q_base, p_base;
  logic [cw-1:0] cnt;
  logic          inflight, k_rd, q_rd, host;

  always_comb begin
    state_nxt = state;
    host      = (state == IDLE);
    cmd_ready = host;
    done      = (state == DONE);
    k_rd      = (state == KLOAD) && (cnt < cw'(col));
    q_rd      = (state == EXEC) && (cnt < cw'(len));
    ofifo_rd  = (state == DRAIN) && (avail != '0) && ((written + (aw+1)'(inflight)) < len);
    q_we      = host && mem_wr && (mem_sel == SEL_Q);
    k_we      = host && mem_wr && (mem_sel == SEL_K);
    host_p_rd = host && !mem_wr && (mem_sel == SEL_P);
    q_ce      = q_we || q_rd;
    k_ce      = k_we || k_rd;
    p_we      = inflight;
    p_ce      = p_we || host_p_rd;
    q_addr    = host ? mem_add : q_base + aw'(cnt);
    k_addr    = host ? mem_add : k_base + aw'(cnt);
    p_addr    = host ? mem_add : p_base + aw'(written);
    case (state)
      IDLE:    if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : KLOAD;
      KLOAD:   if (cnt == cw'(col)) state_nxt = KGAP;
      KGAP:    state_nxt = EXEC;
      EXEC:    if (cnt == cw'(len)) state_nxt = DRAIN;
      DRAIN:   if (written == len) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len      <= '0;
      k_base   <= '0;
      q_base   <= '0;
      p_base   <= '0;
      cnt      <= '0;
      avail    <= '0;
      written  <= '0;
      inflight <= 1'b0;
      inst     <= 2'b00;
    end else begin
      state    <= state_nxt;
      inst     <= {q_rd, k_rd};
      inflight <= ofifo_rd;
      cnt      <= ((state == KLOAD || state == EXEC) && state_nxt == state) ? cnt + cw'(1) : '0;
      if (host && cmd_valid) begin
        len     <= (cmd_len > (aw+1)'(depth)) ? (aw+1)'(depth) : cmd_len;
        k_base  <= cmd_k_base;
        q_base  <= cmd_q_base;
        p_base  <= cmd_p_base;
        avail   <= '0;
        written <= '0;
      end else begin
        avail <= avail + (aw+1)'(row_wr) - (aw+1)'(ofifo_rd);
        if (inflight) written <= written + (aw+1)'(1);
      end
    end
  end

endmodule

// File: rtl/core_seq_sram.sv
// Single-port SRAM model with one-cycle registered read; writes are blocked during reset.
module core_seq_sram #(
  parameter int w     = 64,
  parameter int depth = 16,
  parameter int aw    = $clog2(depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          we,
  input  logic [aw-1:0] addr,
  input  logic [w-1:0]  din,
  output logic [w-1:0]  dout
);

  logic [w-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (ce) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/mac_array.sv
// col-column signed MAC array: inst[0] loads one weight column per cycle, inst[1] computes a psum row.
module mac_array #(
  parameter int col     = 8,
  parameter int pr      = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             inst,
  input  logic [pr*bw-1:0]       din,
  output logic [col*bw_psum-1:0] psum,
  output logic [col-1:0]         fifo_wr
);

  localparam int lw = $clog2(col);

  logic [pr*bw-1:0]       w [col];
  logic [lw-1:0]          ld_ptr;
  logic [col*bw_psum-1:0] psum_nxt;

  for (genvar j = 0; j < col; j++) begin : g_col
    logic signed [bw_psum-1:0] acc;
    always_comb begin
      acc = '0;
      for (int i = 0; i < pr; i++)
        acc = acc + bw_psum'($signed(din[i*bw +: bw])) * bw_psum'($signed(w[j][i*bw +: bw]));
    end
    assign psum_nxt[j*bw_psum +: bw_psum] = acc;
  end

  always_ff @(posedge clk) begin
    if (inst[0]) w[ld_ptr] <= din;
  end

  // load pointer restarts whenever a load burst is not in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_ptr  <= '0;
      fifo_wr <= '0;
      psum    <= '0;
    end else begin
      fifo_wr <= {col{inst[1]}};
      if (inst[1]) psum <= psum_nxt;
      ld_ptr <= inst[0] ? ld_ptr + lw'(1) : '0;
    end
  end

endmodule

// File: rtl/ofifo.sv
// Output row FIFO with registered read data; never overflows since len <= depth.
module ofifo #(
  parameter int w     = 160,
  parameter int depth = 16,
  parameter int aw    = $clog2(depth)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [w-1:0] din,
  input  logic         rd,
  output logic [w-1:0] dout
);

  logic [w-1:0]  mem [depth];
  logic [aw-1:0] wptr, rptr;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      dout <= '0;
    end else begin
      if (wr) wptr <= wptr + aw'(1);
      if (rd) begin
        dout <= mem[rptr];
        rptr <= rptr + aw'(1);
      end
    end
  end

endmodule

// File: rtl/core_seq.sv
// Sequenced q/k/psum datapath with per-row absolute-sum output.
// Optional CORE_SEQ_RELU_EN clamps negative psum lanes to zero before pmem and sum_out.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int col     = 8,
  parameter int pr      = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int depth   = 16,
  parameter int aw      = $clog2(depth)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [aw:0]                    cmd_len,
  input  logic [aw-1:0]                  cmd_k_base,
  input  logic [aw-1:0]                  cmd_q_base,
  input  logic [aw-1:0]                  cmd_p_base,
  output logic                           done,
  input  logic                           mem_wr,
  input  logic [1:0]                     mem_sel,
  input  logic [aw-1:0]                  mem_add,
  input  logic [pr*bw-1:0]               mem_in,
  output logic [bw_psum*col-1:0]         out,
  output logic                           out_valid,
  output logic [bw_psum+$clog2(col)-1:0] sum_out,
  output logic                           sum_valid
);

  localparam int sw = bw_psum + $clog2(col);

  logic                   q_ce, q_we, k_ce, k_we, p_ce, p_we, host_p_rd, ofifo_rd;
  logic [aw-1:0]          q_addr, k_addr, p_addr;
  logic [1:0]             inst;
  logic [pr*bw-1:0]       q_dout, k_dout;
  logic [col-1:0]         fifo_wr;
  logic [col*bw_psum-1:0] mac_psum, fifo_dout, wr_row;

  core_seq_fsm #(.col(col), .depth(depth), .aw(aw)) u_fsm (
    .clk, .reset, .cmd_valid, .cmd_len, .cmd_k_base, .cmd_q_base, .cmd_p_base,
    .mem_wr, .mem_sel, .mem_add, .row_wr(&fifo_wr), .cmd_ready, .done,
    .q_ce, .q_we, .q_addr, .k_ce, .k_we, .k_addr, .p_ce, .p_we, .p_addr,
    .host_p_rd, .inst, .ofifo_rd
  );

  core_seq_sram #(.w(pr*bw), .depth(depth), .aw(aw)) u_qmem (
    .clk, .reset, .ce(q_ce), .we(q_we), .addr(q_addr), .din(mem_in), .dout(q_dout)
  );

  core_seq_sram #(.w(pr*bw), .depth(depth), .aw(aw)) u_kmem (
    .clk, .reset, .ce(k_ce), .we(k_we), .addr(k_addr), .din(mem_in), .dout(k_dout)
  );

  core_seq_sram #(.w(col*bw_psum), .depth(depth), .aw(aw)) u_pmem (
    .clk, .reset, .ce(p_ce), .we(p_we), .addr(p_addr), .din(wr_row), .dout(out)
  );

  mac_array #(.col(col), .pr(pr), .bw(bw), .bw_psum(bw_psum)) u_mac (
    .clk, .reset, .inst, .din(inst[0] ? k_dout : q_dout), .psum(mac_psum), .fifo_wr
  );

  ofifo #(.w(col*bw_psum), .depth(depth), .aw(aw)) u_ofifo (
    .clk, .reset, .wr(&fifo_wr), .din(mac_psum), .rd(ofifo_rd), .dout(fifo_dout)
  );

  always_comb begin
    wr_row = fifo_dout;
`ifdef CORE_SEQ_RELU_EN
    for (int j = 0; j < col; j++)
      if (fifo_dout[j*bw_psum + bw_psum - 1]) wr_row[j*bw_psum +: bw_psum] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum_valid <= 1'b0;
      sum_out   <= '0;
    end else begin
      out_valid <= host_p_rd;
      sum_valid <= p_we;
      if (p_we) sum_out <= sw'(abs_sum(ROW_MAX'(wr_row), col, bw_psum));
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: directed commands against a lane-level reference model.
module tb_core_seq;

  localparam int COL = 8, PR = 8, BW = 8, BWP = 2*BW+4, DEPTH = 16, AW = 4, SW = BWP + 3;

  logic                 clk = 1'b0, reset = 1'b1;
  logic                 cmd_valid = 1'b0, mem_wr = 1'b0;
  logic [AW:0]          cmd_len = '0;
  logic [AW-1:0]        cmd_k_base = '0, cmd_q_base = '0, cmd_p_base = '0, mem_add = '0;
  logic [1:0]           mem_sel = 2'd3;
  logic [PR*BW-1:0]     mem_in = '0;
  logic                 cmd_ready, done, out_valid, sum_valid;
  logic [COL*BWP-1:0]   out;
  logic [SW-1:0]        sum_out;

  core_seq #(.col(COL), .pr(PR), .bw(BW), .bw_psum(BWP), .depth(DEPTH), .aw(AW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_k_base(cmd_k_base), .cmd_q_base(cmd_q_base),
    .cmd_p_base(cmd_p_base), .done(done), .mem_wr(mem_wr), .mem_sel(mem_sel),
    .mem_add(mem_add), .mem_in(mem_in), .out(out), .out_valid(out_valid),
    .sum_out(sum_out), .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, done_cnt = 0, sum_cnt = 0;
  logic [PR*BW-1:0]   qmem_m [DEPTH];
  logic [PR*BW-1:0]   kmem_m [DEPTH];
  logic [COL*BWP-1:0] pmem_m [DEPTH];
  bit                 known  [DEPTH];
  int                 exp_sum[$];

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // every cycle outside reset: count done pulses, check each sum_out update
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (sum_valid) begin
        sum_cnt++;
        if (exp_sum.size() == 0) chk("sum_unexpected", sum_out, '1);
        else chk("sum_out", sum_out, exp_sum.pop_front());
      end
      if (done && cmd_ready) chk("done_with_ready", 1, 0);
    end
  end

  task automatic model_cmd(int len, int kb, int qb, int pb, int keep);
    int le, acc, s;
    logic signed [BW-1:0] qa, wa;
    logic [COL*BWP-1:0] row;
    le = (len > DEPTH) ? DEPTH : len;
    for (int r = 0; r < le && r < keep; r++) begin
      row = '0;
      s = 0;
      for (int j = 0; j < COL; j++) begin
        acc = 0;
        for (int i = 0; i < PR; i++) begin
          qa = qmem_m[(qb + r) % DEPTH][i*BW +: BW];
          wa = kmem_m[(kb + j) % DEPTH][i*BW +: BW];
          acc += int'(qa) * int'(wa);
        end
`ifdef CORE_SEQ_RELU_EN
        if (acc < 0) acc = 0;
`endif
        s += (acc < 0) ? -acc : acc;
        row[j*BWP +: BWP] = BWP'(acc);
      end
      pmem_m[(pb + r) % DEPTH] = row;
      known[(pb + r) % DEPTH]  = 1'b1;
      exp_sum.push_back(s);
    end
  endtask

  task automatic host_wr(int sel, int a, logic [PR*BW-1:0] d);
    @(negedge clk);
    mem_wr = 1'b1; mem_sel = 2'(sel); mem_add = AW'(a); mem_in = d;
    @(posedge clk);
    #1 mem_wr = 1'b0; mem_sel = 2'd3;
    if (sel == 0) qmem_m[a] = d;
    else kmem_m[a] = d;
  endtask

  task automatic host_rd_p(int a);
    @(negedge clk);
    mem_sel = 2'd2; mem_add = AW'(a);
    @(posedge clk);
    #1 mem_sel = 2'd3;
    @(negedge clk);
    chk("out_valid", out_valid, 1);
    if (known[a]) chk($sformatf("pmem_row%0d", a), out, pmem_m[a]);
  endtask

  task automatic issue(int len, int kb, int qb, int pb);
    @(negedge clk);
    cmd_len = (AW+1)'(len); cmd_k_base = AW'(kb); cmd_q_base = AW'(qb); cmd_p_base = AW'(pb);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(int len, int kb, int qb, int pb);
    int d0, s0, le, cyc;
    le = (len > DEPTH) ? DEPTH : len;
    model_cmd(len, kb, qb, pb, le);
    d0 = done_cnt;
    s0 = sum_cnt;
    issue(len, kb, qb, pb);
    if (len == 0) begin
      @(negedge clk);
      chk("len0_done_next_cycle", done, 1);
      #1;
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("cmd_finished_in_budget", cyc < 300, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("sum_pulses", sum_cnt - s0, le);
    chk("sum_queue_drained", exp_sum.size(), 0);
    chk("ready_after_cmd", cmd_ready, 1);
  endtask

  logic [COL*BWP-1:0] lit_row;
  int lit_sum;

  initial begin
    int d0, s0, cyc;
    for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_sum_out", sum_out, 0);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    reset = 1'b0;
    host_rd_p(3);
    @(negedge clk);
    chk("out_valid_single_cycle", out_valid, 0);

    // identity kernel in kmem 0..7; k rows 8..15 lane i = i - j
    for (int j = 0; j < COL; j++) host_wr(1, j, (PR*BW)'(1) << (j*BW));
    for (int j = 0; j < COL; j++) begin
      logic [PR*BW-1:0] d;
      for (int i = 0; i < PR; i++) d[i*BW +: BW] = BW'(i - j);
      host_wr(1, 8 + j, d);
    end
    for (int r = 0; r < DEPTH; r++) begin
      logic [PR*BW-1:0] d;
      for (int i = 0; i < PR; i++) d[i*BW +: BW] = (r < 4) ? BW'(2) : BW'(r*7 + i*3 - 20);
      host_wr(0, r, d);
    end

    run_cmd(4, 0, 0, 0);
    chk("ident_sum_lit", sum_out, 16);
    for (int a = 0; a < 4; a++) host_rd_p(a);
    host_rd_p(0);
    lit_row = {COL{20'd2}};
    chk("ident_row0_lit", out, lit_row);

    run_cmd(4, 0, 14, 15);
    for (int a = 0; a < 3; a++) host_rd_p(a);
    host_rd_p(15);
    chk("wrap_row15_lane0_lit", out[BWP-1:0], 78);

    run_cmd(0, 0, 0, 0);
    run_cmd(20, 0, 0, 0);
    host_rd_p(7);
    host_rd_p(15);

    host_wr(0, 5, {PR{8'hFB}});
    run_cmd(1, 0, 5, 8);
`ifdef CORE_SEQ_RELU_EN
    lit_row = '0;
    lit_sum = 0;
`else
    lit_row = {COL{20'hFFFFB}};
    lit_sum = 40;
`endif
    chk("neg_sum_lit", sum_out, lit_sum);
    host_rd_p(8);
    chk("neg_row_lit", out, lit_row);

    run_cmd(3, 8, 6, 10);
    for (int a = 10; a < 13; a++) host_rd_p(a);

    // abort during drain after two of four pmem writes
    for (int r = 0; r < 4; r++) host_wr(0, r, {PR{8'd3}});
    model_cmd(4, 0, 0, 0, 2);
    d0 = done_cnt;
    s0 = sum_cnt;
    issue(4, 0, 0, 0);
    cyc = 0;
    while (sum_cnt < s0 + 2 && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("abort_reached_drain", cyc < 300, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready_next", cmd_ready, 1);
    repeat (6) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_two_sums", sum_cnt - s0, 2);
    chk("abort_sum_out_cleared", sum_out, 0);
    for (int a = 0; a < 4; a++) host_rd_p(a);
    host_rd_p(0);
    lit_row = {COL{20'd3}};
    chk("abort_row0_lit", out, lit_row);
    host_rd_p(2);
    lit_row = {COL{20'd2}};
    chk("abort_row2_kept_lit", out, lit_row);

    run_cmd(3, 0, 8, 4);
    for (int a = 4; a < 7; a++) host_rd_p(a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Parametrised successor to the single-core datapath.
- Keeps the q/k/psum SRAM + mac_array + ofifo structure. Adds an on-chip sequencer so one host command runs a full kernel-load / execute / drain pass without per-cycle host instructions.
- Adds per-row absolute-sum output for the downstream normaliser.
- Memory depth, column count and widths are generic.

Parameters:
- col, 8, MAC columns / psum lanes per row
- pr, 8, input lanes per row
- bw, 8, activation/weight bit width
- bw_psum, 2*bw+4, psum lane width
- depth, 16, words per SRAM (power of 2)
- aw, $clog2(depth), SRAM address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer idle, command accepted when cmd_valid&cmd_ready
- cmd_len  in  aw+1  Q rows to process (0..depth)
- cmd_k_base  in  aw  kmem start address
- cmd_q_base  in  aw  qmem start address
- cmd_p_base  in  aw  pmem start address
- done  out  1  one-cycle pulse at end of command
- mem_wr  in  1  host write (honoured only in IDLE)
- mem_sel  in  2  0=qmem, 1=kmem, 2=pmem read, 3=reserved
- mem_add  in  aw  host address
- mem_in  in  pr*bw  host write data
- out  out  bw_psum*col  pmem read data
- out_valid  out  1  out holds data for the previous cycle's pmem read
- sum_out  out  bw_psum+$clog2(col)  sum of |psum| over the last drained row
- sum_valid  out  1  pulses with each sum_out update

Behaviour:
- Reset: state=IDLE; cmd_ready=1; done=0; out=0; out_valid=0; sum_out=0; sum_valid=0; row counters=0. mac_array and ofifo receive the same reset.
- Reset mid-command aborts the command: no done, pmem keeps only completed writes, next cycle is IDLE.
- FSM states: IDLE, KLOAD, KGAP, EXEC, DRAIN, DONE.
- IDLE:
  - Host access: mem_wr with sel 0/1 writes mem_in at mem_add.
  - mem_sel=2 without mem_wr reads pmem; out/out_valid valid the next cycle.
  - cmd_valid&cmd_ready latches all cmd fields:
    - cmd_len=0 goes to DONE.
    - cmd_len>depth is clamped to depth.
    - Otherwise go to KLOAD.
  - Host accesses in non-IDLE states are ignored.
- KLOAD:
  - Reads kmem at cmd_k_base+i, i=0..col-1, addresses mod depth.
  - mac_array inst={0,1} (load) with one-cycle SRAM latency alignment: inst asserted the cycle after the read.
  - Lasts col+1 cycles.
- KGAP: one idle cycle, inst=0.
- EXEC:
  - Reads qmem at cmd_q_base+i, i=0..len-1, mod depth.
  - inst={1,0} the cycle after each read.
  - Lasts len+1 cycles.
- Row tracking: avail counter increments on every cycle with &fifo_wr.
- DRAIN:
  - ofifo_rd=1 whenever avail>0 and (written+inflight)<len.
  - Data read at cycle t is written to pmem at cmd_p_base+written (mod depth) at t+1.
  - Simultaneous fifo_wr and ofifo_rd in the same cycle leave avail unchanged.
  - Leave DRAIN when written==len.
- DONE: done=1 for one cycle, cmd_ready=0; next state IDLE.
- sum_out:
  - Registered at the pmem write cycle: sum over lanes of |signed lane|, zero-extended.
  - sum_valid=1 for that cycle. sum_out holds its value otherwise.
- ofifo overflow is impossible by construction (len<=depth<=ofifo depth); no guard is required beyond the clamp.

Optional Feature:
- CORE_SEQ_RELU_EN
  - Defined: each psum lane is clamped to 0 if negative before the pmem write and before the sum_out computation.
  - Undefined: raw signed psums are written and sum_out uses absolute values.

Decomposition:
- Package core_seq_pkg holds:
  - state enum (IDLE..DONE)
  - mem_sel encodings
  - function abs_sum(row) returning the widened lane-abs sum
- Sub-module core_seq_fsm: sequencer, counters and SRAM/mac/ofifo control strobes.
- Top: datapath instances (two generic-depth input SRAMs, one output SRAM, mac_array, ofifo) and the sum_out register.

Test Plan:
- Reset then idle: check cmd_ready=1, done=0, sum_out=0, out_valid=0; host pmem read at addr 3 gives out_valid the next cycle.
- Identity kernel load (kmem row i = one-hot), 4 Q rows of value 2, len=4, p_base=0: pmem[0..3] lanes equal Q sums, done pulses once, 4 sum_valid pulses.
- Wrap-around, depth=16, q_base=14, p_base=15, len=4: reads addresses 14,15,0,1; writes 15,0,1,2.
- cmd_len=0: done the cycle after acceptance, no pmem write. cmd_len=20 with depth=16 is clamped to 16 writes.
- Negative psums (-5 in every lane, col=8): sum_out=40 with macro off; pmem lanes=0 and sum_out=0 with CORE_SEQ_RELU_EN.
- Reset asserted during DRAIN after 2 of 4 writes: no done, cmd_ready=1 next cycle, pmem holds 2 rows; a new command completes normally.
